// File: rtl/window_fetch_if.sv
// rtl/window_fetch_if.sv - index-in, memory-read and window-out signal bundle for window_fetch
interface window_fetch_if #(
    parameter int SIZE   = 16,
    parameter int K      = 4,
    parameter int DATA_W = 16
);
    localparam int AW = $clog2(SIZE);

    logic                idx_valid;
    logic                idx_ready;
    logic [AW*K-1:0]     idx_in;
    logic                mem_rd;
    logic [AW-1:0]       mem_addr;
    logic [DATA_W-1:0]   mem_rdata;
    logic                win_valid;
    logic                win_ready;
    logic [DATA_W*K-1:0] win_data;
    logic                busy;

    modport master (
        input  idx_valid, idx_in, mem_rdata, win_ready,
        output idx_ready, mem_rd, mem_addr, win_valid, win_data, busy
    );

    modport slave (
        output idx_valid, idx_in, mem_rdata, win_ready,
        input  idx_ready, mem_rd, mem_addr, win_valid, win_data, busy
    );
endinterface

// File: rtl/window_fetch.sv
// rtl/window_fetch.sv - fetches K memory words for one index vector and presents them as a window
module window_fetch #(
    parameter int SIZE   = 16,
    parameter int K      = 4,
    parameter int DATA_W = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    window_fetch_if.master bus
);
    localparam int AW = $clog2(SIZE);
    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam logic [CW-1:0] LAST = CW'(K - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, OUT} state_t;

    state_t              state;
    state_t              state_next;
    logic [CW-1:0]       cnt;
    logic [CW-1:0]       cnt_next;
    logic [AW*K-1:0]     cap;
    logic [AW*K-1:0]     cap_next;
    logic [AW-1:0]       cap_slot [K];
    logic [AW-1:0]       addr_next;

    logic                idx_ready_r;
    logic                mem_rd_r;
    logic [AW-1:0]       mem_addr_r;
    logic                win_valid_r;
    logic                busy_r;
    logic [DATA_W*K-1:0] win_data_r;

    // Delayed read strobe and slot number: mem_rdata belongs to last cycle's read.
    logic                rd_q;
    logic [CW-1:0]       cnt_q;

    always_comb begin
        for (int i = 0; i < K; i++) begin
            cap_slot[i] = cap[i*AW +: AW];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            cap   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            cap   <= cap_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        cap_next   = cap;
        addr_next  = '0;
        case (state)
            IDLE: begin
                if (bus.idx_valid && idx_ready_r) begin
                    cap_next   = bus.idx_in;
                    cnt_next   = '0;
                    addr_next  = bus.idx_in[AW-1:0];
                    state_next = FETCH;
                end
            end
            FETCH: begin
                cnt_next = cnt + 1'b1;
                if (cnt == LAST) begin
                    state_next = DRAIN;
                end else begin
                    addr_next = cap_slot[cnt_next];
                end
            end
            DRAIN: begin
                state_next = OUT;
            end
            OUT: begin
                if (bus.win_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they are all low while reset is held.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_ready_r <= 1'b0;
            mem_rd_r    <= 1'b0;
            mem_addr_r  <= '0;
            win_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            idx_ready_r <= (state_next == IDLE);
            mem_rd_r    <= (state_next == FETCH);
            mem_addr_r  <= (state_next == FETCH) ? addr_next : '0;
            win_valid_r <= (state_next == OUT);
            busy_r      <= (state_next != IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_q       <= 1'b0;
            cnt_q      <= '0;
            win_data_r <= '0;
        end else begin
            rd_q  <= mem_rd_r;
            cnt_q <= cnt;
            for (int i = 0; i < K; i++) begin
                if (rd_q && (cnt_q == CW'(i))) begin
                    win_data_r[i*DATA_W +: DATA_W] <= bus.mem_rdata;
                end
            end
        end
    end

    assign bus.idx_ready = idx_ready_r;
    assign bus.mem_rd    = mem_rd_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.win_valid = win_valid_r;
    assign bus.busy      = busy_r;
    assign bus.win_data  = win_data_r;
endmodule
